instr_sequencer: RTL

Multi-cycle sequencer for the 8-bit MIPS core. It owns the program counter and steps each instruction through FETCH, DECODE, EXEC and WB. It fetches from instruction memory over a req/ack handshake and loads the instruction register. It gates the control unit's combinational write strobes (wR, wMD) so they fire for exactly one cycle per instruction, and it applies the control unit's next-PC select (selAddrMI).

---
 rtl/instr_sequencer_if.sv | 37 +++
 rtl/instr_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> core/imem signal bundle for the multi-cycle MIPS sequencer.
// Latency: n/a (wiring only).
// Backpressure: imem_req held until imem_ack; no other stalls.
// master modport: sequencer side (drives pc, imem_req, ir_load, wR_en, wMD_en, busy, illegal, state).
// slave modport : environment side (drives run, step, imem_ack, selAddrMI, wR_cu, wMD_cu, br_off, jmp_addr).
interface instr_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int OFF_W = 4
);
    logic             run;
    logic             step;
    logic             imem_ack;
    logic [1:0]       selAddrMI;
    logic             wR_cu;
    logic             wMD_cu;
    logic [OFF_W-1:0] br_off;
    logic [PC_W-1:0]  jmp_addr;

    logic [PC_W-1:0]  pc;
    logic             imem_req;
    logic             ir_load;
    logic             wR_en;
    logic             wMD_en;
    logic             busy;
    logic             illegal;
    logic [2:0]       state;

    modport master (
        input  run, step, imem_ack, selAddrMI, wR_cu, wMD_cu, br_off, jmp_addr,
        output pc, imem_req, ir_load, wR_en, wMD_en, busy, illegal, state
    );

    modport slave (
        output run, step, imem_ack, selAddrMI, wR_cu, wMD_cu, br_off, jmp_addr,
        input  pc, imem_req, ir_load, wR_en, wMD_en, busy, illegal, state
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: owns PC, steps FETCH/DECODE/EXEC/WB, gates write strobes.
// Latency: 4 cycles per instruction when imem_ack returns in the first FETCH cycle.
// Backpressure: stalls in FETCH (imem_req held, pc stable) until imem_ack.
// Ports: clk, rst_n (async active-low), bus (instr_sequencer_if.master).
// Optional: define SEQ_RETIRE_CNT_EN to add a 16-bit 'retired' instruction counter output.
module instr_sequencer #(
    parameter int              PC_W   = 8,
    parameter int              OFF_W  = 4,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_sequencer_if.master   bus
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]         retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            step_q, step_d;
    logic            illegal_q, illegal_d;
    logic            wr_en_q, wmd_en_q;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] off_sext;

    assign pc_inc   = pc_q + PC_W'(1);
    assign off_sext = {{(PC_W-OFF_W){bus.br_off[OFF_W-1]}}, bus.br_off};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RST_PC;
            step_q    <= 1'b0;
            illegal_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wmd_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            step_q    <= step_d;
            illegal_q <= illegal_d;
            // Captured on the EXEC->WB edge so the strobes are high for the WB cycle only.
            wr_en_q   <= (state_q == S_EXEC) && bus.wR_cu;
            wmd_en_q  <= (state_q == S_EXEC) && bus.wMD_cu;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        step_d    = step_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                    step_d  = 1'b0;
                end else if (bus.step) begin
                    state_d = S_FETCH;
                    step_d  = 1'b1;
                end
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                case (bus.selAddrMI)
                    2'b01: pc_d = pc_inc;
                    2'b10: pc_d = pc_inc + off_sext;
                    2'b11: pc_d = bus.jmp_addr;
                    default: begin
                        // Illegal select still advances sequentially so execution continues.
                        pc_d      = pc_inc;
                        illegal_d = 1'b1;
                    end
                endcase
                state_d = (step_q || !bus.run) ? S_IDLE : S_FETCH;
                step_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.imem_req = (state_q == S_FETCH);
    assign bus.ir_load  = (state_q == S_FETCH) && bus.imem_ack;
    assign bus.wR_en    = wr_en_q;
    assign bus.wMD_en   = wmd_en_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.illegal  = illegal_q;
    assign bus.state    = state_q;

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retired_q;

    // One count per WB cycle; a reset before WB discards the instruction uncounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 16'h0000;
        end else if (state_q == S_WB) begin
            retired_q <= retired_q + 16'h0001;
        end
    end

    assign retired = retired_q;
`endif

endmodule
